// File: rtl/rv32_hazard_ctrl_pkg.sv
// Shared constants for the RV32 hazard controller: forwarding select
// encodings and the freeze FSM state type.
package rv32_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FREEZE = 1'b1
    } hz_state_e;

endpackage

// File: rtl/rv32_fwd_unit.sv
// Operand forwarding select for one EX source register. The youngest
// producer (MEM) wins over WB; x0 is never forwarded.
module rv32_fwd_unit
    import rv32_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_reg_write,
    output logic [1:0]        o_sel
);

    // Pick the nearest in-flight writer of i_rs, else the register file.
    always_comb begin
        o_sel = FWD_RF;
        if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_rs)) begin
            o_sel = FWD_MEM;
        end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/rv32_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core. Keeps a shadow copy
// of the register fields of the instructions in EX/MEM/WB and derives the
// stall/flush/bubble/freeze controls plus the EX forwarding selects.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | pipeline advancing; redirect and load-use handled here
// FREEZE | data memory busy; whole pipeline and shadow state held
module rv32_hazard_ctrl
    import rv32_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    hz_state_e r_state;
    hz_state_e w_state_nxt;

    logic [REG_AW-1:0] r_ex_rd;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic              r_ex_reg_write;
    logic              r_ex_is_load;

    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_reg_write;
    logic              r_mem_is_load;

    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_reg_write;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_load_use;
    logic w_freeze;
    logic w_ex_bubble;
    logic w_stall_inc;
    logic w_flush_inc;

    // MEM load flag is tracked with the rest of the shadow stage but has no
    // consumer inside this block yet.
    logic w_unused;
    assign w_unused = r_mem_is_load;

    // Load in EX whose result the ID instruction needs next cycle.
    assign w_load_use = id_valid && r_ex_is_load && r_ex_reg_write && (r_ex_rd != '0) &&
                        ((id_use_rs1 && (id_rs1 == r_ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == r_ex_rd)));

    // Next state and control outputs; priority is busy > redirect > load-use.
    always_comb begin
        w_state_nxt = r_state;
        w_freeze    = 1'b0;
        w_ex_bubble = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (mem_busy) begin
                    w_state_nxt = ST_FREEZE;
                    w_freeze    = 1'b1;
                end
            end
            ST_FREEZE: begin
                if (mem_busy) begin
                    w_freeze = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        if (w_freeze) begin
            pipe_freeze = 1'b1;
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            w_stall_inc = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            w_ex_bubble = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            w_ex_bubble = 1'b1;
            w_stall_inc = 1'b1;
        end
    end

    // State register, shadow pipeline advance and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_RUN;
            r_ex_rd         <= '0;
            r_ex_rs1        <= '0;
            r_ex_rs2        <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_is_load    <= 1'b0;
            r_mem_rd        <= '0;
            r_mem_reg_write <= 1'b0;
            r_mem_is_load   <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_reg_write  <= 1'b0;
            r_stall_cnt     <= '0;
            r_flush_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_freeze) begin
                r_wb_rd         <= r_mem_rd;
                r_wb_reg_write  <= r_mem_reg_write;
                r_mem_rd        <= r_ex_rd;
                r_mem_reg_write <= r_ex_reg_write;
                r_mem_is_load   <= r_ex_is_load;
                if (w_ex_bubble) begin
                    r_ex_rd        <= '0;
                    r_ex_rs1       <= '0;
                    r_ex_rs2       <= '0;
                    r_ex_reg_write <= 1'b0;
                    r_ex_is_load   <= 1'b0;
                end else begin
                    r_ex_rd        <= id_rd;
                    r_ex_rs1       <= id_rs1;
                    r_ex_rs2       <= id_rs2;
                    r_ex_reg_write <= id_reg_write && id_valid;
                    r_ex_is_load   <= id_is_load && id_valid;
                end
            end
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    rv32_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .i_rs            (r_ex_rs1),
        .i_mem_rd        (r_mem_rd),
        .i_mem_reg_write (r_mem_reg_write),
        .i_wb_rd         (r_wb_rd),
        .i_wb_reg_write  (r_wb_reg_write),
        .o_sel           (fwd_a_sel)
    );

    rv32_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .i_rs            (r_ex_rs2),
        .i_mem_rd        (r_mem_rd),
        .i_mem_reg_write (r_mem_reg_write),
        .i_wb_rd         (r_wb_rd),
        .i_wb_reg_write  (r_wb_reg_write),
        .o_sel           (fwd_b_sel)
    );

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Self-checking bench for rv32_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against an instruction-level model.
module tb_rv32_hazard_ctrl;

    localparam int TB_CNT_W = 6;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                id_valid;
    logic [4:0]          id_rs1, id_rs2, id_rd;
    logic                id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
    logic                ex_redirect, mem_busy;
    logic                pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;
    logic [1:0]          fwd_a_sel, fwd_b_sel;
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    rv32_hazard_ctrl #(.REG_AW(5), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .ex_redirect  (ex_redirect),
        .mem_busy     (mem_busy),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pipe_freeze  (pipe_freeze),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // Instruction in flight as seen by the model: what it writes, what it reads.
    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       wr;
        logic       ld;
    } ins_t;

    ins_t m_pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    int   m_stall;
    int   m_flush;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        for (int k = 1; k <= 2; k++) begin
            if (m_pipe[k].wr && m_pipe[k].rd != 5'd0 && m_pipe[k].rd == rs)
                return (k == 1) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic bit model_load_use();
        ins_t ex = m_pipe[0];
        if (!(id_valid && ex.ld && ex.wr && ex.rd != 5'd0)) return 1'b0;
        return (id_use_rs1 && id_rs1 == ex.rd) || (id_use_rs2 && id_rs2 == ex.rd);
    endfunction

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) m_pipe[k] = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Compare every output against the model, then advance DUT and model by one edge.
    task automatic tick();
        bit   lu, busy, redir, bub;
        ins_t nx;
        lu    = model_load_use();
        busy  = mem_busy;
        redir = ex_redirect;
        bub   = !busy && (redir || lu);
        chk("m_pipe_freeze", pipe_freeze, busy);
        chk("m_pc_stall",    pc_stall,    busy || (!redir && lu));
        chk("m_ifid_stall",  ifid_stall,  busy || (!redir && lu));
        chk("m_ifid_flush",  ifid_flush,  !busy && redir);
        chk("m_idex_bubble", idex_bubble, bub);
        chk("m_fwd_a",       fwd_a_sel,   model_fwd(m_pipe[0].rs1));
        chk("m_fwd_b",       fwd_b_sel,   model_fwd(m_pipe[0].rs2));
        chk("m_stall_cnt",   stall_cnt,   m_stall);
        chk("m_flush_cnt",   flush_cnt,   m_flush);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (!busy) begin
                nx = '0;
                if (!bub) begin
                    nx.rd  = id_rd;
                    nx.rs1 = id_rs1;
                    nx.rs2 = id_rs2;
                    nx.wr  = id_reg_write && id_valid;
                    nx.ld  = id_is_load && id_valid;
                end
                m_pipe[2] = m_pipe[1];
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = nx;
            end
            if (busy || (!redir && lu)) m_stall = sat(m_stall);
            if (!busy && redir)         m_flush = sat(m_flush);
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic set_id(input bit v, input int rd, input int rs1, input int rs2,
                          input bit u1, input bit u2, input bit wr, input bit ld);
        id_valid     = v;
        id_rd        = 5'(rd);
        id_rs1       = 5'(rs1);
        id_rs2       = 5'(rs2);
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_reg_write = wr;
        id_is_load   = ld;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        rst = 1'b1;
        ex_redirect = 1'b0;
        mem_busy = 1'b0;
        idle();
        #1;

        // Reset state
        do_reset();
        settle();
        chk("rst_pc_stall",    pc_stall,    1'b0);
        chk("rst_ifid_flush",  ifid_flush,  1'b0);
        chk("rst_idex_bubble", idex_bubble, 1'b0);
        chk("rst_pipe_freeze", pipe_freeze, 1'b0);
        chk("rst_fwd_a",       fwd_a_sel,   2'b00);
        chk("rst_fwd_b",       fwd_b_sel,   2'b00);
        chk("rst_stall_cnt",   stall_cnt,   0);
        chk("rst_flush_cnt",   flush_cnt,   0);
        tick();

        // add x5,x1,x2 ; sub x6,x5,x3 -> MEM forward
        set_id(1, 5, 1, 2, 1, 1, 1, 0); cyc();
        set_id(1, 6, 5, 3, 1, 1, 1, 0); cyc();
        idle();
        settle(); chk("dep_fwd_a_mem", fwd_a_sel, 2'b01); tick();
        cyc(); cyc();

        // add x5 ; unrelated ; sub x6,x5,x3 -> WB forward
        set_id(1, 5, 1, 2, 1, 1, 1, 0);    cyc();
        set_id(1, 10, 11, 12, 1, 1, 1, 0); cyc();
        set_id(1, 6, 5, 3, 1, 1, 1, 0);    cyc();
        idle();
        settle(); chk("dep_fwd_a_wb", fwd_a_sel, 2'b10); tick();

        // lw x7,0(x1) ; add x8,x7,x7 -> one stall cycle
        do_reset();
        set_id(1, 7, 1, 0, 1, 0, 1, 1); cyc();
        set_id(1, 8, 7, 7, 1, 1, 1, 0);
        settle();
        chk("lu_pc_stall",    pc_stall,    1'b1);
        chk("lu_ifid_stall",  ifid_stall,  1'b1);
        chk("lu_idex_bubble", idex_bubble, 1'b1);
        tick();
        settle();
        chk("lu_stall_gone", pc_stall, 1'b0);
        chk("lu_stall_cnt",  stall_cnt, 1);
        tick();
        idle();
        settle();
        chk("lu_fwd_a_wb", fwd_a_sel, 2'b10);
        chk("lu_fwd_b_wb", fwd_b_sel, 2'b10);
        tick();

        // lw x0 ; add x9,x0,x0 -> no stall, no forward
        set_id(1, 0, 1, 0, 1, 0, 1, 1); cyc();
        set_id(1, 9, 0, 0, 1, 1, 1, 0);
        settle(); chk("x0_no_stall", pc_stall, 1'b0); tick();
        idle();
        settle();
        chk("x0_fwd_a", fwd_a_sel, 2'b00);
        chk("x0_fwd_b", fwd_b_sel, 2'b00);
        tick();

        // Redirect together with load-use: redirect wins
        do_reset();
        set_id(1, 7, 1, 0, 1, 0, 1, 1); cyc();
        set_id(1, 8, 7, 7, 1, 1, 1, 0);
        ex_redirect = 1'b1;
        settle();
        chk("rd_ifid_flush",  ifid_flush,  1'b1);
        chk("rd_idex_bubble", idex_bubble, 1'b1);
        chk("rd_pc_stall",    pc_stall,    1'b0);
        tick();
        ex_redirect = 1'b0;
        idle();
        settle();
        chk("rd_flush_cnt", flush_cnt, 1);
        chk("rd_stall_cnt", stall_cnt, 0);
        tick();

        // Memory freeze with redirect held
        do_reset();
        ex_redirect = 1'b1;
        mem_busy    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("fz_pipe_freeze", pipe_freeze, 1'b1);
            chk("fz_no_flush",    ifid_flush,  1'b0);
            tick();
        end
        mem_busy = 1'b0;
        settle();
        chk("fz_stall_cnt",  stall_cnt,  3);
        chk("fz_flush_on",   ifid_flush, 1'b1);
        chk("fz_unfrozen",   pipe_freeze, 1'b0);
        tick();
        ex_redirect = 1'b0;
        settle();
        chk("fz_flush_cnt", flush_cnt, 1);
        chk("fz_flush_off", ifid_flush, 1'b0);
        tick();

        // Counter saturation
        mem_busy = 1'b1;
        for (int i = 0; i < CNT_MAX + 8; i++) cyc();
        mem_busy = 1'b0;
        settle(); chk("sat_stall_cnt", stall_cnt, CNT_MAX); tick();

        // Randomized traffic, small register range to force dependencies
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            id_valid     = ($urandom_range(0, 9) != 0);
            id_rd        = 5'($urandom_range(0, 5));
            id_rs1       = 5'($urandom_range(0, 5));
            id_rs2       = 5'($urandom_range(0, 5));
            id_use_rs1   = ($urandom_range(0, 3) != 0);
            id_use_rs2   = ($urandom_range(0, 2) != 0);
            id_reg_write = ($urandom_range(0, 4) != 0);
            id_is_load   = ($urandom_range(0, 2) == 0);
            if (!mem_busy) ex_redirect = ($urandom_range(0, 7) == 0);
            mem_busy     = ($urandom_range(0, 5) == 0);
            cyc();
        end
        rst = 1'b0;
        mem_busy = 1'b0;
        ex_redirect = 1'b0;
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
